// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path constants: register address width, hazard FSM
// encodings, counter width and the RV32I major opcodes.
package riscv_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned CNT_W      = 32;

  // Hazard controller FSM encodings (kept as plain constants for legacy users)
  localparam logic [STATE_W-1:0] RUN    = 2'b00;
  localparam logic [STATE_W-1:0] FREEZE = 2'b01;

  // Major opcodes shared with the control path
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_ctrl_sat_cnt32.sv
// sat_cnt32: 32-bit event counter with enable, synchronous active-low clear,
// holding at all-ones instead of wrapping.
module sat_cnt32
  import riscv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Clear dominates; otherwise count enabled events until saturated
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit. Detects load-use hazards, flushes on
// taken branches and freezes the pipeline while data memory is busy. A branch
// resolved during a freeze is remembered and applied when the freeze ends.
// Optional performance counters are enabled with macro HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  if_id_flush,
  output logic                  set_control_zero,
  output logic [STATE_W-1:0]    state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               bp_q, bp_d;
  logic               load_use;
  logic               br;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign br = ex_branch_taken | bp_q;

  // Next-state and pipeline control; any non-RUN encoding behaves as FREEZE
  always_comb begin
    state_d          = RUN;
    bp_d             = 1'b0;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    id_ex_write      = 1'b1;
    if_id_flush      = 1'b0;
    set_control_zero = 1'b0;
    if (dmem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      state_d     = FREEZE;
      bp_d        = (state_q == RUN) ? ex_branch_taken : (bp_q | ex_branch_taken);
    end else if (br) begin
      if_id_flush      = 1'b1;
      set_control_zero = 1'b1;
    end else if (load_use) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      set_control_zero = 1'b1;
    end
    // Reset holds the pipeline with a bubble, independent of registered state
    if (!rst_n) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      id_ex_write      = 1'b0;
      if_id_flush      = 1'b1;
      set_control_zero = 1'b1;
    end
  end

  // FSM state and pending-branch register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      bp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bp_q    <= bp_d;
    end
  end

  assign state = rst_n ? state_q : RUN;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_hit, flush_hit;

  assign stall_hit = ~dmem_busy & ~br & load_use;
  assign flush_hit = ~dmem_busy & br;

  sat_cnt32 u_stall_cnt  (.clk(clk), .clr_n(rst_n), .en(stall_hit), .count(stall_cnt));
  sat_cnt32 u_flush_cnt  (.clk(clk), .clr_n(rst_n), .en(flush_hit), .count(flush_cnt));
  sat_cnt32 u_freeze_cnt (.clk(clk), .clr_n(rst_n), .en(dmem_busy), .count(freeze_cnt));
`endif

endmodule
